// File: rtl/kyber_encode_pkg.sv
// Shared constants, state encoding and helpers for the streaming ByteEncode datapath.
package kyber_encode_pkg;

    localparam int unsigned KYBER_N = 256;
    localparam int unsigned KYBER_Q = 3329;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } enc_state_e;

    // True when d is a supported bit width (1..dmax).
    function automatic logic legal_d(input logic [3:0] d, input int unsigned dmax);
        return (d != 4'd0) && (32'(d) <= dmax);
    endfunction

    // Encoded polynomial length in bytes for width d.
    function automatic int unsigned enc_bytes(input logic [3:0] d);
        return 32'd32 * 32'(d);
    endfunction

endpackage

// File: rtl/coeff_normalize.sv
// Maps a signed coefficient in (-Q, Q) onto [0, Q) by a conditional add of Q.
module coeff_normalize
    import kyber_encode_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic signed [15:0] coef,
    output logic [15:0]        v
);

    assign v = $unsigned(coef) + (coef[15] ? 16'(Q) : 16'd0);

endmodule

// File: rtl/encode_stream.sv
// Streaming ByteEncode_d: packs the low d bits of each normalised coefficient LSB-first
// and emits the 32*d-byte encoding one byte per valid/ready beat.
module encode_stream
    import kyber_encode_pkg::*;
#(
    parameter int unsigned DMAX = 12,
    parameter int unsigned N    = KYBER_N,
    parameter int unsigned Q    = KYBER_Q
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         d_sel,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic signed [15:0] coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic               busy,
    output logic               err
);

    localparam int unsigned AW = DMAX + 7;
    localparam int unsigned FW = $clog2(AW + 1);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned BW = $clog2(32 * DMAX);

    enc_state_e    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [FW-1:0] fill_q, fill_d, fill_eff;
    logic [3:0]    d_reg_q, d_reg_d, d_use;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          err_q, err_d;
    logic          ready_en_q;
    logic          pop, accept, push, d_legal;
    logic [15:0]   v, v_mask;

    coeff_normalize #(
        .Q(Q)
    ) u_norm (
        .coef(coef),
        .v   (v)
    );

    assign out_valid = fill_q >= FW'(8);
    assign out_byte  = acc_q[7:0];
    assign out_last  = out_valid && (state_q == DRAIN) &&
                       (bcnt_q == BW'(enc_bytes(d_reg_q) - 1));
    assign busy      = state_q != IDLE;
    assign err       = err_q;

    // Accept only if the accumulator still has room after this cycle's pop.
    assign pop        = out_valid && out_ready;
    assign fill_eff   = pop ? fill_q - FW'(8) : fill_q;
    assign coef_ready = ready_en_q && (state_q != DRAIN) && (fill_eff < FW'(8));
    assign accept     = coef_valid && coef_ready;
    assign d_legal    = legal_d(d_sel, DMAX);
    assign d_use      = (state_q == IDLE) ? d_sel : d_reg_q;
    assign push       = accept && ((state_q != IDLE) || d_legal);
    assign v_mask     = v & ((16'd1 << d_use) - 16'd1);

    assign acc_d  = (pop ? acc_q >> 8 : acc_q) | (push ? AW'(v_mask) << fill_eff : '0);
    assign fill_d = fill_eff + (push ? FW'(d_use) : '0);

    always_comb begin
        state_d = state_q;
        d_reg_d = d_reg_q;
        ccnt_d  = ccnt_q;
        bcnt_d  = pop ? bcnt_q + BW'(1) : bcnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (d_legal) begin
                        d_reg_d = d_sel;
                        ccnt_d  = CW'(1);
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (ccnt_q == CW'(N - 1)) begin
                        ccnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        ccnt_d = ccnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fill_q     <= '0;
            d_reg_q    <= '0;
            ccnt_q     <= '0;
            bcnt_q     <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            d_reg_q    <= d_reg_d;
            ccnt_q     <= ccnt_d;
            bcnt_q     <= bcnt_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_encode_stream.sv
// Bench for encode_stream: table of whole-polynomial vectors checked against a bit-level
// ByteEncode model and hand-computed leading bytes, plus error and mid-stream reset sequences.
module tb_encode_stream;

    logic               clk;
    logic               rst_n;
    logic [3:0]         d_sel;
    logic               coef_valid;
    logic               coef_ready;
    logic signed [15:0] coef;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_byte;
    logic               out_last;
    logic               busy;
    logic               err;

    int checks = 0;
    int errors = 0;

    int         coefs[256];
    logic [7:0] exp_bytes[384];

    typedef struct {
        int          d;
        int          pat;        // 0: i, 1: alternating 0/1, 2: pairs (-1,0), 3: random
        bit          rnd;        // random out_ready
        bit          abort;      // run an aborted polynomial plus reset first
        int          first_ci;   // accepts completed when out_valid first rises
        int          cycles;     // beats until last byte handshake, 0 = unchecked
        bit          hand_ok;
        logic [47:0] hand;       // first six bytes, byte 0 in [7:0]
    } vec_t;

    vec_t tbl[6];

    encode_stream u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_sel     (d_sel),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef      (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic gen_coefs(input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       coefs[i] = i;
                1:       coefs[i] = i % 2;
                2:       coefs[i] = (i % 2 == 0) ? -1 : 0;
                default: coefs[i] = int'($urandom_range(0, 6656)) - 3328;
            endcase
        end
    endtask

    // Reference ByteEncode: bit j of coefficient i lands at stream bit i*d+j.
    task automatic build_exp(input int d);
        for (int k = 0; k < 384; k++) exp_bytes[k] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            int v;
            v = (coefs[i] < 0) ? coefs[i] + 3329 : coefs[i];
            for (int j = 0; j < d; j++) begin
                int pos;
                pos = i * d + j;
                exp_bytes[pos / 8][pos % 8] = v[j];
            end
        end
    endtask

    task automatic run_poly(input int row);
        int d, nb, ci, bi, cyc, first_ci, err_seen, idx;
        logic stall, sl;
        logic [7:0] sb;
        d = tbl[row].d;
        nb = 32 * d;
        gen_coefs(tbl[row].pat);
        build_exp(d);
        ci = 0; bi = 0; cyc = 0; first_ci = -1; err_seen = 0;
        stall = 1'b0; sl = 1'b0; sb = 8'h00;
        while (bi < nb && cyc < 4000) begin
            @(posedge clk); #1;
            idx        = (ci < 256) ? ci : 0;
            coef_valid = (ci < 256);
            coef       = 16'(coefs[idx]);
            d_sel      = (ci == 0) ? 4'(d) : 4'($urandom_range(0, 15));
            out_ready  = tbl[row].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (err) err_seen++;
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_byte", out_byte, sb);
                check("hold_last", out_last, sl);
            end
            if (out_valid && first_ci < 0) first_ci = ci;
            if (coef_valid && coef_ready) ci++;
            if (out_valid && out_ready) begin
                check($sformatf("row%0d byte%0d", row, bi), out_byte, exp_bytes[bi]);
                if (tbl[row].hand_ok && bi < 6)
                    check($sformatf("row%0d hand%0d", row, bi), out_byte, tbl[row].hand[bi*8 +: 8]);
                check($sformatf("row%0d last%0d", row, bi), out_last, (bi == nb - 1));
                bi++;
            end
            stall = out_valid && !out_ready;
            sb    = out_byte;
            sl    = out_last;
        end
        if (bi < nb) begin
            errors++;
            $display("FAIL row%0d timeout: got %0d bytes required %0d", row, bi, nb);
        end
        check($sformatf("row%0d accepts", row), ci, 256);
        check($sformatf("row%0d first_valid", row), first_ci, tbl[row].first_ci);
        if (tbl[row].cycles != 0) check($sformatf("row%0d cycles", row), cyc, tbl[row].cycles);
        check($sformatf("row%0d err_pulses", row), err_seen, 0);
        @(posedge clk); #1;
        coef_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        check($sformatf("row%0d busy_after", row), busy, 0);
        check($sformatf("row%0d valid_after", row), out_valid, 0);
    endtask

    task automatic illegal_beat(input logic [3:0] dv);
        @(posedge clk); #1;
        coef_valid = 1'b1;
        d_sel      = dv;
        coef       = 16'sd77;
        out_ready  = 1'b1;
        @(negedge clk);
        check("illegal_ready", coef_ready, 1);
        @(posedge clk); #1;
        coef_valid = 1'b0;
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_clear", err, 0);
    endtask

    task automatic abort_poly();
        int ci, cyc;
        logic last_seen;
        ci = 0; cyc = 0; last_seen = 1'b0;
        while (ci < 100 && cyc < 1000) begin
            @(posedge clk); #1;
            coef_valid = 1'b1;
            coef       = 16'(ci * 37 - 1000);
            d_sel      = 4'd7;
            out_ready  = 1'b1;
            @(negedge clk);
            cyc++;
            if (out_last) last_seen = 1'b1;
            if (coef_valid && coef_ready) ci++;
        end
        check("abort_accepts", ci, 100);
        @(posedge clk); #1;
        coef_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", coef_ready, 0);
        check("abort_valid", out_valid, 0);
        check("abort_byte", out_byte, 0);
        check("abort_last", out_last, 0);
        check("abort_busy0", busy, 0);
        check("abort_err", err, 0);
        check("abort_no_last", last_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_back", coef_ready, 1);
    endtask

    initial begin
        tbl[0] = '{d: 8,  pat: 0, rnd: 0, abort: 0, first_ci: 1, cycles: 257, hand_ok: 1,
                   hand: 48'h050403020100};
        tbl[1] = '{d: 12, pat: 0, rnd: 0, abort: 0, first_ci: 1, cycles: 385, hand_ok: 1,
                   hand: 48'h003002001000};
        tbl[2] = '{d: 1,  pat: 1, rnd: 0, abort: 0, first_ci: 8, cycles: 257, hand_ok: 1,
                   hand: 48'hAAAAAAAAAAAA};
        tbl[3] = '{d: 12, pat: 2, rnd: 0, abort: 0, first_ci: 1, cycles: 385, hand_ok: 1,
                   hand: 48'h000D00000D00};
        tbl[4] = '{d: 10, pat: 3, rnd: 1, abort: 0, first_ci: 1, cycles: 0,   hand_ok: 0,
                   hand: 48'h0};
        tbl[5] = '{d: 5,  pat: 0, rnd: 0, abort: 1, first_ci: 2, cycles: 257, hand_ok: 1,
                   hand: 48'h28398A418820};

        rst_n      = 1'b0;
        d_sel      = 4'd0;
        coef_valid = 1'b0;
        coef       = 16'sd0;
        out_ready  = 1'b0;
        #3;
        check("rst_ready", coef_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_byte", out_byte, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", coef_ready, 1);
        check("idle_busy", busy, 0);

        illegal_beat(4'd0);
        illegal_beat(4'd13);

        for (int r = 0; r < 6; r++) begin
            if (tbl[r].abort) abort_poly();
            run_poly(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encode_stream.md
# encode_stream

Streaming, multi-width successor to the combinational ByteEncode_d block. It accepts one signed 16-bit polynomial coefficient per beat and normalises it to [0, q). It packs the low d bits LSB-first into a bit accumulator and emits the 32·d-byte encoding one byte per beat. d is selectable per polynomial at runtime. It sits between the NTT/compress datapath and the ciphertext/public-key byte buffer, replacing the 256-wide parallel encoder with a valid/ready pipeline stage.

## Interface
- `DMAX`, 12: largest supported d; sets accumulator width `DMAX+7` = 19 bits.
- `N`, 256: coefficients per polynomial.
- `Q`, 3329: Kyber modulus used for normalisation.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `d_sel`  in  4  bit width for the polynomial; sampled only on its first accepted coefficient; legal range 1..DMAX.
- `coef_valid`  in  1  coefficient beat valid.
- `coef_ready`  out  1  coefficient beat accepted when valid&&ready.
- `coef`  in  16  signed coefficient, range (−Q, Q).
- `out_valid`  out  1  output byte valid.
- `out_ready`  in  1  downstream accepts byte.
- `out_byte`  out  8  packed byte.
- `out_last`  out  1  marks byte index 32·d−1.
- `busy`  out  1  polynomial in progress (state ≠ IDLE).
- `err`  out  1  one-cycle pulse: illegal d_sel on a first beat.

## Operation
- Normalise: `v = coef + (coef<0 ? Q : 0)`, then take `v[d-1:0]`. For d=12 this yields the canonical value.
- Accumulator `acc[18:0]` with fill count `fill` in the range 0..19.
  - Push: `acc |= v << fill_eff`, `fill += d`.
  - Pop: `acc >>= 8`, `fill -= 8`.
  - `fill_eff = fill − 8·pop`.
  - Push and pop may occur in the same cycle.
- Output regs: `out_valid = (fill ≥ 8)`, `out_byte = acc[7:0]`.
- `coef_ready = state∈{IDLE,RUN} && fill_eff < 8`. This is combinational on `out_ready`, by design.
- Counters:
  - `ccnt` (0..N−1) counts accepted coefficients.
  - `bcnt` (0..32·DMAX−1) counts popped bytes.
- FSM:
  - IDLE: `coef_ready=1`. On accept:
    - If d_sel is legal: latch `d_reg`, push, go to RUN.
    - If d_sel is illegal: consume and discard the beat, pulse `err`, stay IDLE.
  - RUN: accept coefficients. When the N-th coefficient is accepted, go to DRAIN.
  - DRAIN: `coef_ready=0`. Pop remaining bytes. On the pop with `bcnt = 32·d_reg−1` (the `out_last` beat), clear counters and go to IDLE.
- N·d is always a multiple of 8, so `fill = 0` exactly at `out_last`. No padding byte is emitted.
- `d_sel` changes mid-polynomial are ignored; `d_reg` governs.

## Timing
- Reset values: `coef_ready=0` while `rst_n=0`, and 1 from the first clock in IDLE. `out_valid=0`, `out_byte=0`, `out_last=0`, `busy=0`, `err=0`, `fill=0`, both counters 0.
- Latency: the first byte is `out_valid` 1 cycle after the accept that makes `fill ≥ 8`.
  - For d=8 that is the first coefficient.
  - For d=1 it is the 8th coefficient.
- Throughput:
  - d≤8: 1 coefficient/cycle.
  - d>8: 1 byte/cycle, bounded by the output side.
  - No bubbles under continuous `out_ready`.
- Backpressure:
  - With `out_ready=0`, `out_valid`/`out_byte`/`out_last` hold stable.
  - `coef_ready` falls once `fill ≥ 8`.
  - No beat is lost or duplicated.
- The first coefficient of the next polynomial may be accepted in the cycle after the `out_last` handshake.
- Asynchronous reset mid-polynomial: all state is discarded immediately, outputs go to reset values, and no `out_last` is emitted.

## Structure
- Package `kyber_encode_pkg` holds:
  - `KYBER_N` and `KYBER_Q`;
  - enum `enc_state_e {IDLE, RUN, DRAIN}`;
  - function `legal_d(d)`, true when 1 ≤ d ≤ DMAX;
  - function `enc_bytes(d)`, returns 32·d.
- One sub-module: `coeff_normalize` (signed 16-bit → [0,Q) by conditional add of Q), purely combinational.

## Test plan
- d=8, coef[i]=i, `out_ready=1` → out_byte[i]=i for i=0..255. `out_last` only at byte 255. `busy` drops the next cycle.
- d=12, coef 0,1,2,3… → bytes 0x00,0x10,0x00,0x02,0x30,0x00… 384 bytes total, `out_last` at byte 383.
- d=1, coef alternating 0,1 → 32 bytes, all 0xAA. First `out_valid` follows the 8th accept.
- d=12, coef pairs (−1,0) → 3328=0xD00 encodes as bytes 0x00,0x0D,0x00, repeated.
- d=10, `out_ready` random 50%, coef random in (−Q,Q) → byte stream matches the reference ByteEncode model. Never more than 19 bits buffered, no stalls lost.
- Other directed cases:
  - d_sel=0 on first beat → `err` 1-cycle pulse, state stays IDLE.
  - `rst_n` low after coefficient 100 → all outputs go to 0 immediately. A following d=5 polynomial encodes correctly (160 bytes).
